// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded RV32I fields (I-type, S-type, shift)
// plus a 32-bit immediate into an instruction word, range-checks the
// immediate and streams legal words into instruction memory at sequential
// word addresses through a valid/ready write port.
//
// Handshakes: a transfer happens on a rising clock edge where both sides
// of a pair are high (in_valid && in_ready, wr_en && wr_ready); once
// raised, wr_en, wr_addr and wr_data stay stable until that edge.
//
// Optional feature macro: SELF_CHECK_EN re-decodes each legal word with
// the core's immediate rules and pulses chk_err on disagreement.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              enc_err,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              chk_err
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENC   = 2'd1,
        WRITE = 2'd2,
        FULL  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } bundle_t;

    state_t              state_q, state_d;
    bundle_t             bun_q, bun_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                enc_err_q, enc_err_d;
    logic                full_q, full_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                chk_err_q, chk_err_d;

    logic [31:0]         enc_word;
    logic                enc_legal;
    logic                imm12_ok;
    logic                chk_mismatch;
    logic [ADDR_W:0]     count_inc;

    assign count_inc = count_q + 1'b1;

    // Pack the captured bundle and decide whether it is encodable.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        // A 12-bit signed immediate fits when bits 31..11 are a pure sign run.
        imm12_ok  = (&bun_q.imm[31:11]) | ~(|bun_q.imm[31:11]);
        case (bun_q.fmt)
            2'd0: begin
                enc_word  = {bun_q.imm[11:0], bun_q.rs1, bun_q.funct3,
                             bun_q.rd, bun_q.opcode};
                enc_legal = imm12_ok;
            end
            2'd1: begin
                enc_word  = {bun_q.imm[11:5], bun_q.rs2, bun_q.rs1,
                             bun_q.funct3, bun_q.imm[4:0], bun_q.opcode};
                enc_legal = imm12_ok;
            end
            2'd2: begin
                enc_word  = {1'b0, bun_q.funct7_5, 5'b0, bun_q.imm[4:0],
                             bun_q.rs1, bun_q.funct3, bun_q.rd, bun_q.opcode};
                // Only SLLI (001, funct7_5=0) and SRLI/SRAI (101) exist.
                enc_legal = ~(|bun_q.imm[31:5]) &&
                            ((bun_q.funct3 == 3'b101) ||
                             (bun_q.funct3 == 3'b001 && !bun_q.funct7_5));
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

`ifdef SELF_CHECK_EN
    logic [31:0] dec_imm;

    // Re-decode the packed word the way the core would and compare.
    always_comb begin
        dec_imm      = '0;
        chk_mismatch = 1'b0;
        if (bun_q.fmt == 2'd1) begin
            dec_imm = {{20{enc_word[31]}}, enc_word[31:25], enc_word[11:7]};
        end else if (enc_word[14:12] == 3'b101 && enc_word[30] &&
                     bun_q.fmt == 2'd2) begin
            dec_imm = {27'b0, enc_word[24:20]};
        end else begin
            dec_imm = {{20{enc_word[31]}}, enc_word[31:20]};
        end
        if (bun_q.fmt == 2'd2) begin
            chk_mismatch = (dec_imm[4:0] != bun_q.imm[4:0]);
        end else begin
            chk_mismatch = (dec_imm != bun_q.imm);
        end
    end
`else
    assign chk_mismatch = 1'b0;
`endif

    // Next-state and next-output logic; clear overrides every state.
    always_comb begin
        state_d    = state_q;
        bun_d      = bun_q;
        in_ready_d = in_ready_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        enc_err_d  = 1'b0;
        full_d     = full_q;
        count_d    = count_q;
        chk_err_d  = 1'b0;
        if (clear) begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
            wr_en_d    = 1'b0;
            wr_addr_d  = BASE_C;
            count_d    = '0;
            full_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_d = 1'b1;
                    if (in_valid) begin
                        bun_d      = '{fmt: fmt, opcode: opcode, funct3: funct3,
                                       funct7_5: funct7_5, rd: rd, rs1: rs1,
                                       rs2: rs2, imm: imm};
                        in_ready_d = 1'b0;
                        state_d    = ENC;
                    end
                end
                ENC: begin
                    if (enc_legal) begin
                        wr_data_d = enc_word;
                        wr_en_d   = 1'b1;
                        chk_err_d = chk_mismatch;
                        state_d   = WRITE;
                    end else begin
                        enc_err_d  = 1'b1;
                        in_ready_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_en_d   = 1'b0;
                        wr_addr_d = wr_addr_q + 1'b1;
                        count_d   = count_inc;
                        if (count_inc == DEPTH_C) begin
                            full_d     = 1'b1;
                            in_ready_d = 1'b0;
                            state_d    = FULL;
                        end else begin
                            in_ready_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                end
                FULL: begin
                    full_d     = 1'b1;
                    in_ready_d = 1'b0;
                end
                default: begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs; reset drops wr_en immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bun_q      <= '0;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_C;
            wr_data_q  <= '0;
            enc_err_q  <= 1'b0;
            full_q     <= 1'b0;
            count_q    <= '0;
            chk_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bun_q      <= bun_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            enc_err_q  <= enc_err_d;
            full_q     <= full_d;
            count_q    <= count_d;
            chk_err_q  <= chk_err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign enc_err  = enc_err_q;
    assign full     = full_q;
    assign count    = count_q;
    assign chk_err  = chk_err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader (DEPTH=4 so the full/clear path is reached
// quickly). Directed vectors first, then randomized bundles checked against
// an arithmetic reference model.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int BASE   = 0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              enc_err;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              chk_err;

  int n_vec = 0;
  int n_err = 0;
  int m_count = 0;
  logic [31:0] obs_data;
  logic [31:0] exp_q[$];

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .enc_err(enc_err), .full(full), .count(count), .chk_err(chk_err)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // move to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: encodability from the signed value of the immediate
  function automatic void ref_encode(input logic [1:0] f, input logic [6:0] op,
                                     input logic [2:0] f3, input logic f7,
                                     input logic [4:0] rd_i, input logic [4:0] rs1_i,
                                     input logic [4:0] rs2_i, input logic [31:0] im,
                                     output bit legal, output logic [31:0] w);
    longint v;
    logic [11:0] lo12;
    v = longint'($signed(im));
    lo12 = im[11:0];
    legal = 0;
    w = '0;
    case (f)
      2'd0: begin
        legal = (v >= -2048) && (v <= 2047);
        w = {lo12, rs1_i, f3, rd_i, op};
      end
      2'd1: begin
        legal = (v >= -2048) && (v <= 2047);
        w = {lo12[11:5], rs2_i, rs1_i, f3, lo12[4:0], op};
      end
      2'd2: begin
        legal = (v >= 0) && (v <= 31) && ((f3 == 3'd5) || (f3 == 3'd1 && f7 == 1'b0));
        w = {1'b0, f7, 5'b0, lo12[4:0], rs1_i, f3, rd_i, op};
      end
      default: legal = 0;
    endcase
  endfunction

  task automatic drive(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic [4:0] rd_i, input logic [4:0] rs1_i,
                       input logic [4:0] rs2_i, input logic [31:0] im);
    in_valid = 1'b1; fmt = f; opcode = op; funct3 = f3; funct7_5 = f7;
    rd = rd_i; rs1 = rs1_i; rs2 = rs2_i; imm = im;
  endtask

  // offer one bundle; wr_ready is held low for 'stall' cycles of the write
  task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic [4:0] rd_i, input logic [4:0] rs1_i,
                      input logic [4:0] rs2_i, input logic [31:0] im, input int stall);
    bit legal;
    logic [31:0] w;
    int n;
    ref_encode(f, op, f3, f7, rd_i, rs1_i, rs2_i, im, legal, w);
    if (m_count == DEPTH) begin
      chk("full_in_ready", 32'(in_ready), 32'd0);
      drive(f, op, f3, f7, rd_i, rs1_i, rs2_i, im);
      step();
      in_valid = 1'b0;
      step();
      chk("full_ignore_wr_en", 32'(wr_en), 32'd0);
      chk("full_ignore_err", 32'(enc_err), 32'd0);
      chk("full_flag", 32'(full), 32'd1);
      chk("full_count", 32'(count), 32'(DEPTH));
      return;
    end
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    drive(f, op, f3, f7, rd_i, rs1_i, rs2_i, im);
    step();
    in_valid = 1'b0;
    wr_ready = (stall == 0);
    chk("enc_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("chk_err", 32'(chk_err), 32'd0);
    if (!legal) begin
      chk("enc_err_pulse", 32'(enc_err), 32'd1);
      chk("err_no_wr_en", 32'(wr_en), 32'd0);
      step();
      chk("enc_err_drop", 32'(enc_err), 32'd0);
      chk("err_in_ready", 32'(in_ready), 32'd1);
      chk("err_count", 32'(count), 32'(m_count));
    end else begin
      exp_q.push_back(w);
      chk("no_enc_err", 32'(enc_err), 32'd0);
      obs_data = wr_data;
      for (int c = 0; c <= stall; c++) begin
        chk("wr_en_hold", 32'(wr_en), 32'd1);
        chk("wr_addr", 32'(wr_addr), 32'((BASE + m_count) % (1 << ADDR_W)));
        chk("wr_data", wr_data, exp_q[0]);
        wr_ready = (c == stall);
        step();
      end
      void'(exp_q.pop_front());
      wr_ready = 1'b0;
      m_count++;
      chk("wr_en_drop", 32'(wr_en), 32'd0);
      chk("count", 32'(count), 32'(m_count));
      chk("full_state", 32'(full), 32'(m_count == DEPTH));
      chk("post_in_ready", 32'(in_ready), 32'(m_count != DEPTH));
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_count = 0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    chk("clr_addr", 32'(wr_addr), 32'(BASE));
    chk("clr_wr_en", 32'(wr_en), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(BASE));
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_enc_err"}, 32'(enc_err), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_chk_err"}, 32'(chk_err), 32'd0);
  endtask

  initial begin
    logic [1:0]  rf;
    logic [2:0]  rf3;
    logic [31:0] rim;
    int n;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    fmt = '0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    step();
    step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // directed vectors
    send(2'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 0);
    chk("tp_addi5", obs_data, 32'h0050_0093);
    send(2'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFFF, 0);
    chk("tp_addi_m1", obs_data, 32'hFFF0_8093);
    send(2'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2048, 0);
    send(2'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFF_F800, 0);
    send(2'd1, 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 3);
    chk("tp_sw", obs_data, 32'h0020_A423);
    do_clear();
    send(2'd2, 7'h13, 3'd5, 1'b1, 5'd3, 5'd3, 5'd0, 32'd4, 0);
    chk("tp_srai", obs_data, 32'h4041_D193);
    send(2'd2, 7'h13, 3'd5, 1'b1, 5'd3, 5'd3, 5'd0, 32'd32, 0);
    send(2'd2, 7'h13, 3'd1, 1'b1, 5'd3, 5'd3, 5'd0, 32'd4, 0);
    send(2'd3, 7'h13, 3'd0, 1'b0, 5'd3, 5'd3, 5'd0, 32'd4, 0);

    // fill to DEPTH, then one more that must be ignored
    do_clear();
    for (int i = 0; i < 5; i++)
      send(2'd0, 7'h13, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i * 3), 0);
    do_clear();
    send(2'd0, 7'h13, 3'd0, 1'b0, 5'd7, 5'd2, 5'd0, 32'd100, 1);

    // clear aborts a write that completes in the same cycle
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    drive(2'd0, 7'h13, 3'd0, 1'b0, 5'd4, 5'd4, 5'd0, 32'd9);
    step();
    in_valid = 1'b0;
    wr_ready = 1'b0;
    step();
    chk("abort_wr_en_up", 32'(wr_en), 32'd1);
    wr_ready = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    wr_ready = 1'b0;
    m_count = 0;
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_addr", 32'(wr_addr), 32'(BASE));

    // asynchronous reset in the middle of a write
    drive(2'd1, 7'h23, 3'd2, 1'b0, 5'd0, 5'd5, 5'd6, 32'hFFFF_FFF0);
    step();
    in_valid = 1'b0;
    step();
    chk("rst_pre_wr_en", 32'(wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    step();
    rst_n = 1'b1;
    m_count = 0;
    step();

    // randomized bundles
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_clear();
      end else begin
        rf = 2'($urandom_range(0, 3));
        if (rf == 2'd2) begin
          n = $urandom_range(0, 2);
          rf3 = (n == 0) ? 3'd1 : (n == 1) ? 3'd5 : 3'($urandom);
          rim = 32'($urandom_range(0, 40));
        end else begin
          rf3 = 3'($urandom);
          rim = ($urandom_range(0, 7) == 0) ? $urandom
                                            : 32'($urandom_range(0, 8191)) - 32'd4096;
        end
        send(rf, 7'($urandom), rf3, 1'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), rim, $urandom_range(0, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
